led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
- Parametrised successor to the fixed 8-LED pattern block, for the TM1638 LED bank.
- Drives WIDTH LEDs with one of four run-time-selectable animations:
  - ACCUM, the "sang don" accumulating stack.
  - FILL.
  - CHASE.
  - BOUNCE.
- Advances one animation step every (div+1) rising edges of the slow `tick` input.
- Supports direction mirroring, hold (freeze) and an end-of-frame pulse.

Parameters:
- WIDTH, 8, number of LEDs; legal range 2..32.
- DIV_W, 4, width of the `div` tick-prescaler input.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- tick  in  1  slow timing input, any duty cycle; only rising edges count.
- mode  in  2  animation select: 0 ACCUM, 1 FILL, 2 CHASE, 3 BOUNCE.
- dir  in  1  0 = normal (bit 0 first); 1 = output bit-mirrored.
- hold  in  1  1 = freeze animation and prescaler.
- div  in  DIV_W  step every div+1 tick rising edges.
- led  out  WIDTH  registered LED drive, 1 = lit.
- frame_done  out  1  one-clk pulse when the animation wraps to frame start.

Behaviour:
- Reset (reset==0 at a clk edge):
  - Outputs: led=0, frame_done=0.
  - Internal state: tick_q=0, prescale count=0, k=0, p=0, up=1, latched mode=0.
  - Reset has priority over all other inputs, including mid-frame.
- Tick edge detection: tick_edge = tick & ~tick_q, with tick_q registered every clk.
- Prescaler:
  - On a tick_edge with hold==0: if count==div then assert step and set count=0; otherwise count+1.
  - div=0 means every tick edge is a step.
  - While hold==1, count and all animation state are frozen and led holds its value.
- Step, single cycle: at the step clk edge, led <= pattern(state) and state <= next(state). Latency is 1 clk from the sampled tick rise to the led update.
- Mode change: mode is compared against the latched mode at each step. If it differs:
  - Latch the new mode.
  - State becomes the frame start of the new mode.
  - led shows the new mode's frame-start pattern.
  - frame_done is not asserted.
- ACCUM (k = stacked LEDs at the top, p = moving dot):
  - pattern = top-k mask | (1<<p).
  - If p == WIDTH-1-k: k++ and p=0. If k reaches WIDTH there, wrap to k=0, p=0.
  - Otherwise p++.
  - Frame length is WIDTH(WIDTH+1)/2 steps.
- FILL: pattern = (1<<(k+1))-1 for k=0..WIDTH-1, then one all-zero step, then wrap. Frame is WIDTH+1 steps.
- CHASE: pattern = 1<<p; p runs 0..WIDTH-1, then wraps.
- BOUNCE: pattern = 1<<p.
  - p ping-pongs 0→WIDTH-1→0; the endpoints are not repeated.
  - Frame is 2*WIDTH-2 steps; wrap occurs when moving down into p=0.
- dir: a combinational bit-reverse of the pattern before the led register. It does not change state, and toggling it mid-frame takes effect at the next step.
- frame_done: asserted for exactly the step clk at which led is loaded with the frame-start pattern due to wrap. It is not asserted on the first step after reset or on a mode change.
- Width rules:
  - k and p are $clog2(WIDTH+1) bits.
  - All shifts are computed at WIDTH bits; no truncation warnings are allowed.
- Simultaneous events:
  - A tick edge during hold==1 is discarded.
  - A mode change and a wrap on the same step: the mode change wins and frame_done stays 0.

Decomposition:
- Shared package led_pattern_pkg:
  - Mode localparams MODE_ACCUM/FILL/CHASE/BOUNCE (2-bit).
  - The mirror function.
- Sub-module tick_prescaler, containing:
  - The tick_q edge detector.
  - The DIV_W counter.
  - The hold gating.
  - The single-cycle `step` output.
- The top module holds the mode FSM, the k/p/up registers, and the led and frame_done registers.

Test Plan:
- WIDTH=4, mode=0, div=0, dir=0, 10 tick rises → led = 0001,0010,0100,1000,1001,1010,1100,1101,1110,1111. The 11th rise gives 0001 with a one-clk frame_done.
- WIDTH=8, mode=2, div=2 → led changes only on every 3rd tick rise: 01,02,04…80, then 01 with frame_done.
- WIDTH=8, mode=3, dir=1 → led = 80,40,…,01,02,…,40, then 80 with frame_done. That is 14 steps, with no repeated endpoint.
- WIDTH=8, mode=1:
  - Run 3 steps, then assert hold for 10 tick rises, then release → led holds 07 throughout, and the next steps give 0F,1F.
  - Switching mode to 2 at that point → the next step gives led=01 and frame_done=0.
- Mid-frame reset (reset=0 for 1 clk at ACCUM step 6) → led=00 next clk; the first step after release gives 01 with frame_done=0.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// led_pattern_pkg: mode encodings and bit-mirror helper shared by the LED pattern generator
package led_pattern_pkg;
    localparam logic [1:0] MODE_ACCUM  = 2'd0;
    localparam logic [1:0] MODE_FILL   = 2'd1;
    localparam logic [1:0] MODE_CHASE  = 2'd2;
    localparam logic [1:0] MODE_BOUNCE = 2'd3;

    function automatic logic [31:0] mirror32(input logic [31:0] x);
        for (int i = 0; i < 32; i++) mirror32[i] = x[31 - i];
    endfunction
endpackage

// File: rtl/led_pattern_gen_tick_prescaler.sv
// tick_prescaler: tick rising-edge detector and div+1 prescaler, frozen while hold is high
module tick_prescaler #(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic             step
);
    logic             tick_q;
    logic [DIV_W-1:0] count;
    logic             fire;

    assign fire = tick & ~tick_q & ~hold;
    assign step = fire & (count == div);

    always_ff @(posedge clk) begin
        if (!reset) begin
            tick_q <= 1'b0;
            count  <= '0;
        end else begin
            tick_q <= tick;
            if (fire) count <= step ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/led_pattern_gen.sv
// led_pattern_gen: WIDTH-LED animation engine (accumulate/fill/chase/bounce) with mirror, hold and frame pulse
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic             hold,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] led,
    output logic             frame_done
);
    localparam int KW = $clog2(WIDTH + 1);
    localparam logic [KW-1:0] LAST = KW'(WIDTH - 1);
    localparam logic [KW-1:0] FULL = KW'(WIDTH);
    localparam logic [WIDTH-1:0] ONES = '1;

    logic             step, chg, cup, up, nup, dn, wrap, wrap_q;
    logic [1:0]       mode_q;
    logic [KW-1:0]    k, p, ck, cp, nk, np;
    logic [WIDTH-1:0] one, pat, led_d;

    tick_prescaler #(.DIV_W(DIV_W)) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .tick (tick),
        .hold (hold),
        .div  (div),
        .step (step)
    );

    // A mode change restarts from the common frame start (k=0, p=0, up=1) within the same step
    always_comb begin
        chg  = mode != mode_q;
        ck   = chg ? '0 : k;
        cp   = chg ? '0 : p;
        cup  = chg | up;
        one  = WIDTH'(1) << cp;
        pat  = one;
        nk   = ck;
        np   = cp + 1'b1;
        nup  = 1'b1;
        dn   = 1'b0;
        wrap = 1'b0;
        case (mode)
            MODE_ACCUM: begin
                pat  = ~(ONES >> ck) | one;
                wrap = ck == LAST && cp == '0;
                nk   = wrap ? '0 : (cp == LAST - ck ? ck + 1'b1 : ck);
                np   = cp == LAST - ck ? '0 : cp + 1'b1;
            end
            MODE_FILL: begin
                pat  = ck == FULL ? '0 : ONES >> (LAST - ck);
                wrap = ck == FULL;
                nk   = wrap ? '0 : ck + 1'b1;
                np   = '0;
            end
            MODE_CHASE: begin
                wrap = cp == LAST;
                np   = wrap ? '0 : cp + 1'b1;
            end
            default: begin
                dn   = !cup || cp == LAST;
                np   = dn ? cp - 1'b1 : cp + 1'b1;
                nup  = !dn || np == '0;
                wrap = dn && np == '0;
            end
        endcase
        led_d = dir ? WIDTH'(mirror32(32'(pat)) >> (32 - WIDTH)) : pat;
    end

    // wrap_q remembers that the state just wrapped, so the next displayed start pattern pulses frame_done
    always_ff @(posedge clk) begin
        if (!reset) begin
            led        <= '0;
            frame_done <= 1'b0;
            k          <= '0;
            p          <= '0;
            up         <= 1'b1;
            mode_q     <= MODE_ACCUM;
            wrap_q     <= 1'b0;
        end else begin
            frame_done <= step & ~chg & wrap_q;
            if (step) begin
                led    <= led_d;
                k      <= nk;
                p      <= np;
                up     <= nup;
                mode_q <= mode;
                wrap_q <= wrap;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_gen.sv
// tb_led_pattern_gen: scoreboard bench with a frame-table reference model and randomized tick/mode/hold stimulus
module tb_led_pattern_gen;
    localparam int W  = 8;
    localparam int DW = 4;

    typedef struct packed {
        logic [W-1:0] led;
        logic         fd;
    } exp_t;

    logic          clk = 1'b0, reset = 1'b0, tick = 1'b0, dir = 1'b0, hold = 1'b0;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] div = '0;
    logic [W-1:0]  led;
    logic          frame_done;

    led_pattern_gen #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .mode      (mode),
        .dir       (dir),
        .hold      (hold),
        .div       (div),
        .led       (led),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    exp_t         sb[$];
    int           checks = 0, passed = 0;
    logic [W-1:0] fr[4][64];
    int           flen[4];
    int           m_mode, m_idx, m_cnt;
    bit           m_fresh;
    logic [W-1:0] m_led;
    logic         mon_tq = 1'b0, mon_edge, mon_rst;
    exp_t         mon_e;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] x);
        for (int i = 0; i < W; i++) rev[W - 1 - i] = x[i];
    endfunction

    // One full frame per mode, written straight from the animation rules
    task automatic build_frames();
        int n;
        n = 0;
        for (int kk = 0; kk < W; kk++)
            for (int pp = 0; pp < W - kk; pp++) begin
                fr[0][n] = W'(((32'd1 << kk) - 1) << (W - kk)) | W'(32'd1 << pp);
                n++;
            end
        flen[0] = n;
        for (int kk = 0; kk < W; kk++) fr[1][kk] = W'((32'd1 << (kk + 1)) - 1);
        fr[1][W] = '0;
        flen[1] = W + 1;
        for (int pp = 0; pp < W; pp++) fr[2][pp] = W'(32'd1 << pp);
        flen[2] = W;
        n = 0;
        for (int pp = 0; pp < W; pp++) begin fr[3][n] = W'(32'd1 << pp); n++; end
        for (int pp = W - 2; pp >= 1; pp--) begin fr[3][n] = W'(32'd1 << pp); n++; end
        flen[3] = n;
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_idx   = 0;
        m_cnt   = 0;
        m_fresh = 1;
        m_led   = '0;
    endtask

    // Raise tick at a negedge with the current controls; predict what the DUT shows after the next edge
    task automatic rise(input int hi);
        @(negedge clk);
        tick = 1'b1;
        if (hold) sb.push_back('{m_led, 1'b0});
        else if (m_cnt != int'(div)) begin
            m_cnt = (m_cnt + 1) % (1 << DW);
            sb.push_back('{m_led, 1'b0});
        end else begin
            m_cnt = 0;
            if (int'(mode) != m_mode) begin
                m_mode  = int'(mode);
                m_idx   = 0;
                m_fresh = 1;
            end
            m_led = dir ? rev(fr[m_mode][m_idx]) : fr[m_mode][m_idx];
            sb.push_back('{m_led, (m_idx == 0 && !m_fresh)});
            m_fresh = 0;
            m_idx   = (m_idx + 1) % flen[m_mode];
        end
        repeat (hi) @(negedge clk);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        tick  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        model_reset();
    endtask

    initial begin
        forever begin
            @(posedge clk);
            mon_edge = reset && tick && !mon_tq;
            mon_rst  = !reset;
            mon_tq   = reset && tick;
            #1;
            if (mon_rst) begin
                check("reset_led", 32'(led), 32'd0);
                check("reset_frame_done", 32'(frame_done), 32'd0);
            end else if (mon_edge) begin
                if (sb.size() == 0) check("scoreboard_underflow", 32'd1, 32'd0);
                else begin
                    mon_e = sb.pop_front();
                    check("led", 32'(led), 32'(mon_e.led));
                    check("frame_done", 32'(frame_done), 32'(mon_e.fd));
                end
            end else check("frame_done_idle", 32'(frame_done), 32'd0);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not complete, %0d/%0d checks passed so far", passed, checks);
        $fatal(1);
    end

    initial begin
        build_frames();
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        mode = 2'd0; div = 4'd0; dir = 1'b0;
        repeat (flen[0] + 1) rise(1);
        mode = 2'd2; div = 4'd2;
        repeat (3 * (W + 1)) rise(1);
        mode = 2'd3; div = 4'd0; dir = 1'b1;
        repeat (2 * W - 1) rise(1);
        mode = 2'd1; dir = 1'b0;
        repeat (3) rise(1);
        hold = 1'b1;
        repeat (10) rise(2);
        hold = 1'b0;
        repeat (2) rise(1);
        mode = 2'd2;
        rise(1);
        mode = 2'd0;
        repeat (6) rise(1);
        do_reset();
        repeat (3) rise(1);
        repeat (400) begin
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            hold = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 31) == 0) div = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 99) == 0) do_reset();
            rise($urandom_range(1, 3));
        end
        repeat (3) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
